// File: rtl/k005297_pkg.sv
// Shared constants and slot-phase decode for the K005297 serial timer blocks.
package k005297_pkg;

  localparam int TMR_W            = 12;
  localparam int ROT_W            = 20;
  localparam int SLOT_SHIFT_FIRST = 0;
  localparam int SLOT_SHIFT_LAST  = 11;
  localparam int SLOT_EVAL        = 12;
  localparam int SLOT_LOAD        = 19;

  typedef enum logic [1:0] {
    PH_SHIFT,
    PH_EVAL,
    PH_LOAD,
    PH_IDLE
  } phase_e;

  // ROT20 is one-hot-low; a malformed strobe resolves by priority order.
  function automatic phase_e slot_phase(input logic [ROT_W-1:0] rot_n);
    phase_e ph;
    if (!(&rot_n[SLOT_SHIFT_LAST:SLOT_SHIFT_FIRST])) ph = PH_SHIFT;
    else if (!rot_n[SLOT_EVAL])                      ph = PH_EVAL;
    else if (!rot_n[SLOT_LOAD])                      ph = PH_LOAD;
    else                                             ph = PH_IDLE;
    return ph;
  endfunction

endpackage

// File: rtl/k005297_fsub.sv
// 1-bit full subtractor: d = a - b - bin, bout set when the result borrows.
module k005297_fsub (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/k005297_downtimer.sv
// 12-bit serial down-counter: LSB-first decrement once per ROT20 frame,
// saturating at zero, with a slot-19 parallel reload path.
module k005297_downtimer
  import k005297_pkg::*;
(
  input  logic             i_MCLK,
  input  logic             i_RST_n,
  input  logic             i_CLK2M_PCEN_n,
  input  logic [19:0]      i_ROT20_n,
  input  logic [11:0]      i_LOAD_VAL,
  input  logic             i_LOAD_REQ,
  output logic             o_LOAD_ACK,
  input  logic             i_CNT_EN,
  output logic             o_ZERO_n,
  output logic             o_BUSY,
  output logic [11:0]      o_CURVAL
);

  logic [TMR_W-1:0] cnt_q, cnt_d;
  logic [TMR_W-1:0] hold_q, hold_d;
  logic [TMR_W-1:0] curval_q, curval_d;
  logic             pend_q, pend_d;
  logic             brw_q, brw_d;
  logic             zacc_q, zacc_d;
  logic             zf_q, zf_d;
  logic             ce_q, ce_d;
  logic             ack_q, ack_d;

  logic             tick;
  logic             slot0;
  phase_e           phase;
  logic             borrow_in;
  logic             diff;
  logic             bout;
  logic [TMR_W-1:0] load_val;

  assign tick  = ~i_CLK2M_PCEN_n;
  assign slot0 = ~i_ROT20_n[SLOT_SHIFT_FIRST];
  assign phase = slot_phase(i_ROT20_n);

  // The initial borrow is suppressed at zero, which is what makes the count saturate.
  assign borrow_in = slot0 ? (i_CNT_EN & ~zf_q) : brw_q;

  // A request landing on the slot-19 tick bypasses HOLD.
  assign load_val = i_LOAD_REQ ? i_LOAD_VAL : hold_q;

  k005297_fsub u_fsub (
    .a    (cnt_q[0]),
    .b    (borrow_in),
    .bin  (1'b0),
    .d    (diff),
    .bout (bout)
  );

  always_comb begin
    cnt_d    = cnt_q;
    hold_d   = hold_q;
    curval_d = curval_q;
    pend_d   = pend_q;
    brw_d    = brw_q;
    zacc_d   = zacc_q;
    zf_d     = zf_q;
    ce_d     = ce_q;
    ack_d    = ack_q;

    if (tick) begin
      ack_d = 1'b0;
      if (i_LOAD_REQ) begin
        hold_d = i_LOAD_VAL;
        pend_d = 1'b1;
      end

      unique case (phase)
        PH_SHIFT: begin
          if (slot0) ce_d = i_CNT_EN;
          cnt_d  = {diff, cnt_q[TMR_W-1:1]};
          brw_d  = bout;
          zacc_d = (slot0 ? 1'b0 : zacc_q) | diff;
        end
        PH_EVAL: begin
          zf_d     = ~zacc_q;
          curval_d = cnt_q;
        end
        PH_LOAD: begin
          if (pend_q || i_LOAD_REQ) begin
            cnt_d  = load_val;
            zf_d   = (load_val == '0);
            pend_d = 1'b0;
            brw_d  = 1'b0;
            ack_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_MCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      cnt_q    <= '0;
      hold_q   <= '0;
      curval_q <= '0;
      pend_q   <= 1'b0;
      brw_q    <= 1'b0;
      zacc_q   <= 1'b0;
      zf_q     <= 1'b1;
      ce_q     <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      curval_q <= curval_d;
      pend_q   <= pend_d;
      brw_q    <= brw_d;
      zacc_q   <= zacc_d;
      zf_q     <= zf_d;
      ce_q     <= ce_d;
      ack_q    <= ack_d;
    end
  end

  assign o_LOAD_ACK = ack_q;
  assign o_BUSY     = pend_q;
  assign o_ZERO_n   = ~zf_q;
  assign o_CURVAL   = curval_q;

endmodule

// File: tb/tb_k005297_downtimer.sv
// Directed bench for k005297_downtimer: bench-side slot counter drives ROT20.
module tb_k005297_downtimer;

  logic        clk;
  logic        rst_n;
  logic        pcen_n;
  logic [19:0] rot_n;
  logic [11:0] load_val;
  logic        load_req;
  logic        load_ack;
  logic        cnt_en;
  logic        zero_n;
  logic        busy;
  logic [11:0] curval;

  int errors;
  int checks;
  int slot;

  k005297_downtimer dut (
    .i_MCLK         (clk),
    .i_RST_n        (rst_n),
    .i_CLK2M_PCEN_n (pcen_n),
    .i_ROT20_n      (rot_n),
    .i_LOAD_VAL     (load_val),
    .i_LOAD_REQ     (load_req),
    .o_LOAD_ACK     (load_ack),
    .i_CNT_EN       (cnt_en),
    .o_ZERO_n       (zero_n),
    .o_BUSY         (busy),
    .o_CURVAL       (curval)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One enabled tick at the current bench slot; outputs sampled 1 time unit after the edge.
  task automatic step();
    rot_n = ~(20'd1 << slot);
    @(posedge clk);
    #1;
    slot = (slot + 1) % 20;
  endtask

  task automatic run_to(input int s);
    while (slot != s) step();
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    pcen_n   = 1'b0;
    rot_n    = '1;
    load_val = '0;
    load_req = 1'b0;
    cnt_en   = 1'b1;
    slot     = 0;
    @(posedge clk);
    #1;
    checks++;
    if (zero_n !== 1'b0 || curval !== 12'd0 || busy !== 1'b0 || load_ack !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: zero_n=%b curval=%h busy=%b ack=%b, want 0 000 0 0",
               zero_n, curval, busy, load_ack);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      step();
      checks++;
      if (zero_n !== 1'b0 || curval !== 12'd0 || busy !== 1'b0 || load_ack !== 1'b0) begin
        errors++;
        $display("FAIL freerun_idle tick %0d: zero_n=%b curval=%h busy=%b ack=%b, want 0 000 0 0",
                 i, zero_n, curval, busy, load_ack);
      end
    end
    $display("test_reset: done, errors=%0d", errors);
  endtask

  task automatic test_load_count();
    cnt_en = 1'b1;
    run_to(5);
    load_req = 1'b1;
    load_val = 12'd3;
    step();
    load_req = 1'b0;
    while (slot != 19) begin
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL busy_pending slot %0d: busy=%b want 1", slot, busy);
      end
      step();
    end
    step();
    checks++;
    if (load_ack !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ack_slot19: ack=%b busy=%b want 1 0", load_ack, busy);
    end
    step();
    checks++;
    if (load_ack !== 1'b0) begin
      errors++;
      $display("FAIL ack_pulse_width: ack=%b want 0", load_ack);
    end
    for (int k = 1; k <= 8; k++) begin
      run_to(12);
      if (k == 3) begin
        checks++;
        if (zero_n !== 1'b1) begin
          errors++;
          $display("FAIL zero_early: zero_n=%b want 1", zero_n);
        end
      end
      step();
      checks++;
      if (curval !== 12'((k < 3) ? 3 - k : 0) || zero_n !== ((k < 3) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL countdown frame %0d: curval=%0d zero_n=%b want %0d %b",
                 k, curval, zero_n, (k < 3) ? 3 - k : 0, (k < 3) ? 1'b1 : 1'b0);
      end
    end
    $display("test_load_count: done, errors=%0d", errors);
  endtask

  task automatic test_borrow_ripple();
    cnt_en = 1'b1;
    run_to(10);
    load_req = 1'b1;
    load_val = 12'h800;
    step();
    load_req = 1'b0;
    run_to(19);
    step();
    checks++;
    if (load_ack !== 1'b1) begin
      errors++;
      $display("FAIL ripple_ack: ack=%b want 1", load_ack);
    end
    run_to(12);
    step();
    checks++;
    if (curval !== 12'h7FF || zero_n !== 1'b1) begin
      errors++;
      $display("FAIL borrow_ripple: curval=%h zero_n=%b want 7ff 1", curval, zero_n);
    end
    $display("test_borrow_ripple: done, errors=%0d", errors);
  endtask

  task automatic test_cnt_en_midframe();
    cnt_en = 1'b1;
    run_to(3);
    load_req = 1'b1;
    load_val = 12'd10;
    step();
    load_req = 1'b0;
    run_to(19);
    step();
    run_to(6);
    cnt_en = 1'b0;
    run_to(12);
    step();
    checks++;
    if (curval !== 12'd9) begin
      errors++;
      $display("FAIL en_sampled_slot0: curval=%0d want 9", curval);
    end
    run_to(12);
    step();
    checks++;
    if (curval !== 12'd9 || zero_n !== 1'b1) begin
      errors++;
      $display("FAIL en_low_hold: curval=%0d zero_n=%b want 9 1", curval, zero_n);
    end
    $display("test_cnt_en_midframe: done, errors=%0d", errors);
  endtask

  task automatic test_back_to_back();
    int acks;
    cnt_en = 1'b0;
    run_to(2);
    load_req = 1'b1;
    load_val = 12'h123;
    step();
    load_req = 1'b0;
    run_to(15);
    load_req = 1'b1;
    load_val = 12'h456;
    step();
    load_req = 1'b0;
    acks = 0;
    while (slot != 13) begin
      step();
      if (load_ack === 1'b1) acks++;
    end
    checks++;
    if (acks != 1 || curval !== 12'h456 || busy !== 1'b0) begin
      errors++;
      $display("FAIL overwrite: acks=%0d curval=%h busy=%b want 1 456 0", acks, curval, busy);
    end
    run_to(19);
    load_req = 1'b1;
    load_val = 12'h0AA;
    step();
    load_req = 1'b0;
    checks++;
    if (load_ack !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL slot19_bypass_ack: ack=%b busy=%b want 1 0", load_ack, busy);
    end
    run_to(12);
    step();
    checks++;
    if (curval !== 12'h0AA || zero_n !== 1'b1) begin
      errors++;
      $display("FAIL slot19_bypass_value: curval=%h zero_n=%b want 0aa 1", curval, zero_n);
    end
    $display("test_back_to_back: done, errors=%0d", errors);
  endtask

  task automatic test_clock_enable();
    pcen_n   = 1'b1;
    rot_n    = ~(20'd1 << 19);
    load_req = 1'b1;
    load_val = 12'h000;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (load_ack !== 1'b0 || busy !== 1'b0 || zero_n !== 1'b1 || curval !== 12'h0AA) begin
        errors++;
        $display("FAIL pcen_hold cycle %0d: ack=%b busy=%b zero_n=%b curval=%h want 0 0 1 0aa",
                 i, load_ack, busy, zero_n, curval);
      end
    end
    load_req = 1'b0;
    pcen_n   = 1'b0;
    $display("test_clock_enable: done, errors=%0d", errors);
  endtask

  task automatic test_load_zero();
    cnt_en = 1'b1;
    run_to(8);
    load_req = 1'b1;
    load_val = 12'h000;
    step();
    load_req = 1'b0;
    run_to(19);
    checks++;
    if (zero_n !== 1'b1) begin
      errors++;
      $display("FAIL zero_before_load: zero_n=%b want 1", zero_n);
    end
    step();
    checks++;
    if (zero_n !== 1'b0 || load_ack !== 1'b1) begin
      errors++;
      $display("FAIL load_zero: zero_n=%b ack=%b want 0 1", zero_n, load_ack);
    end
    run_to(12);
    step();
    checks++;
    if (curval !== 12'h000 || zero_n !== 1'b0) begin
      errors++;
      $display("FAIL no_wrap: curval=%h zero_n=%b want 000 0", curval, zero_n);
    end
    $display("test_load_zero: done, errors=%0d", errors);
  endtask

  task automatic test_reset_midcount();
    cnt_en = 1'b1;
    run_to(10);
    load_req = 1'b1;
    load_val = 12'd100;
    step();
    load_req = 1'b0;
    run_to(19);
    step();
    run_to(12);
    step();
    checks++;
    if (curval !== 12'd99) begin
      errors++;
      $display("FAIL count_from_100: curval=%0d want 99", curval);
    end
    run_to(5);
    load_req = 1'b1;
    load_val = 12'd50;
    step();
    load_req = 1'b0;
    run_to(7);
    checks++;
    if (busy !== 1'b1 || zero_n !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: busy=%b zero_n=%b want 1 1", busy, zero_n);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (zero_n !== 1'b0 || curval !== 12'd0 || busy !== 1'b0 || load_ack !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: zero_n=%b curval=%h busy=%b ack=%b want 0 000 0 0",
               zero_n, curval, busy, load_ack);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    slot  = 0;
    for (int f = 0; f < 2; f++) begin
      run_to(12);
      step();
      checks++;
      if (curval !== 12'd0 || zero_n !== 1'b0) begin
        errors++;
        $display("FAIL post_reset frame %0d: curval=%h zero_n=%b want 000 0", f, curval, zero_n);
      end
    end
    $display("test_reset_midcount: done, errors=%0d", errors);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_load_count();
    test_borrow_ripple();
    test_cnt_en_midframe();
    test_back_to_back();
    test_clock_enable();
    test_load_zero();
    test_reset_midcount();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
